// File: rtl/ahb_pkg.sv
// AHB bus encodings (HTRANS, HRESP, HSIZE) and the memory-slave FSM states.
// Shared by the AHB master, the multiplexers and ahb_mem_slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } mem_state_e;

  function automatic logic size_ok(logic [2:0] s);
    return s <= HSIZE_WORD;
  endfunction

endpackage

// File: rtl/ahb_mem_bytelane.sv
// Byte-enable decode for the memory slave: (addr[1:0], size) -> be[3:0].
// Little-endian lanes; halfword/word ignore low address bits below alignment.
module ahb_mem_bytelane
  import ahb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size == HSIZE_BYTE: be = 4'b0001 << addr_lo;
      size == HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      size == HSIZE_WORD: be = 4'b1111;
      default:            be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: 2^ADDR_W words, WAIT_STATES waits per OKAY phase, ERROR
// for illegal access. Ports: AHB slave side (hsel/haddr/htrans/hwrite/hsize/
// hburst/hready/hwdata in; hrdata/hreadyout/hresp out). Optional
// AHB_MEM_ALIGN_CHECK_EN turns misaligned accesses into ERROR.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  mem_state_e state_q, state_d;

  logic [ADDR_W+1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [3:0]        cnt_q;
  logic [31:0]       mem [DEPTH];

  logic       ready_st;
  logic       accept;
  logic       range_ok;
  logic       align_ok;
  logic       legal;
  logic       commit;
  logic [3:0] be;

  // Burst type and the BUSY/IDLE distinction carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  assign ready_st = (state_q == ST_IDLE) ||
                    (state_q == ST_DONE) ||
                    (state_q == ST_ERR2);
  assign accept   = hsel & hready & htrans[1] & ready_st;
  assign range_ok = (haddr >> (ADDR_W + 2)) == 32'd0;

`ifdef AHB_MEM_ALIGN_CHECK_EN
  assign align_ok = !((hsize == HSIZE_HALF && haddr[0]) ||
                      (hsize == HSIZE_WORD && haddr[1:0] != 2'b00));
`else
  assign align_ok = 1'b1;
`endif

  assign legal  = range_ok & size_ok(hsize) & align_ok;
  assign commit = (state_q == ST_DONE) & write_q;

  ahb_mem_bytelane u_bytelane (
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .be      (be)
  );

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      cnt_q   <= 4'd0;
    end else begin
      if (accept) begin
        addr_q  <= haddr[ADDR_W+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
      if (accept && legal)
        cnt_q <= WS;
      else if (state_q == ST_WAIT)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept)     state_d = ST_IDLE;
        else if (!legal) state_d = ST_ERR1;
        else if (WS != 4'd0) state_d = ST_WAIT;
        else             state_d = ST_DONE;
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = 32'd0;
    unique case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_DONE: begin
        if (!write_q) hrdata = mem[addr_q[ADDR_W+1:2]];
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Contents survive reset; only the in-flight write is dropped.
  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Self-checking bench for ahb_mem_slave: directed + random transfers vs a
// byte-level memory model; second instance with zero wait states.
module tb_ahb_mem_slave;

  localparam int WS1 = 1;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        ws0_sel;

  logic        hsel0, hsel1, hready;
  logic [31:0] rd0, rd1, hrdata_m;
  logic        ro0, ro1;
  logic [1:0]  rs0, rs1, hresp_m;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [1024];

  always #5 hclk = ~hclk;

  assign hsel0    = hsel & ws0_sel;
  assign hsel1    = hsel & ~ws0_sel;
  assign hready   = ws0_sel ? ro0 : ro1;
  assign hrdata_m = ws0_sel ? rd0 : rd1;
  assign hresp_m  = ws0_sel ? rs0 : rs1;

  ahb_mem_slave #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .hclk (hclk), .hreset (hreset), .hsel (hsel0), .haddr (haddr),
    .htrans (htrans), .hwrite (hwrite), .hsize (hsize), .hburst (hburst),
    .hready (hready), .hwdata (hwdata), .hrdata (rd0),
    .hreadyout (ro0), .hresp (rs0)
  );

  ahb_mem_slave #(.ADDR_W(10), .WAIT_STATES(WS1)) u_dut1 (
    .hclk (hclk), .hreset (hreset), .hsel (hsel1), .haddr (haddr),
    .htrans (htrans), .hwrite (hwrite), .hsize (hsize), .hburst (hburst),
    .hready (hready), .hwdata (hwdata), .hrdata (rd1),
    .hreadyout (ro1), .hresp (rs1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(logic [31:0] a, logic [2:0] s);
    if (a >= 32'h1000) return 1'b0;
    if (s > 3'd2) return 1'b0;
`ifdef AHB_MEM_ALIGN_CHECK_EN
    if ((a & ((32'd1 << s) - 32'd1)) != 32'd0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] d);
    int nb;
    logic [31:0] base;
    int lane;
    nb   = 1 << s;
    base = a & ~32'(nb - 1);
    for (int b = 0; b < nb; b++) begin
      lane = int'((base + 32'(b)) % 32'd4);
      ref_mem[a[11:2]][lane*8 +: 8] = d[lane*8 +: 8];
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] resp,
                      output logic [1:0] resp0, output logic rdy0,
                      output int waits);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = s;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    rdy0  = hready;
    resp0 = hresp_m;
    waits = 0;
    while (!hready && waits < 40) begin
      waits++;
      @(negedge hclk);
    end
    if (!hready) begin
      tests++;
      fails++;
      $display("FAIL xfer_timeout addr=%h observed=no_ready required=ready", a);
    end
    rd   = hrdata_m;
    resp = hresp_m;
  endtask

  task automatic do_xfer(input string tag, input bit wr,
                         input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d);
    logic [31:0] rd;
    logic [1:0]  rs, rsf;
    logic        rdy0;
    int          w, ws;
    ws = ws0_sel ? 0 : WS1;
    xfer(wr, a, s, d, rd, rs, rsf, rdy0, w);
    if (is_legal(a, s)) begin
      check({tag, "/waits"}, 32'(w), 32'(ws));
      check({tag, "/resp"}, 32'(rs), 32'd0);
      if (!wr) check({tag, "/rdata"}, rd, ref_mem[a[11:2]]);
      else     model_write(a, s, d);
    end else begin
      check({tag, "/err1_resp"}, 32'(rsf), 32'd1);
      check({tag, "/err1_rdy"}, 32'(rdy0), 32'd0);
      check({tag, "/err2_resp"}, 32'(rs), 32'd1);
      check({tag, "/err_len"}, 32'(w), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b000; hburst = 3'b000; hwdata = '0;
    ws0_sel = 1'b0;
    repeat (3) @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    check("rst/ready", 32'(ro1), 32'd1);
    check("rst/resp", 32'(rs1), 32'd0);
    check("rst/rdata", rd1, 32'd0);
    check("rst/ready0", 32'(ro0), 32'd1);

    do_xfer("w_dead", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    do_xfer("r_dead", 1'b0, 32'h10, 3'd2, 32'h0);
    do_xfer("w_base", 1'b1, 32'h10, 3'd2, 32'h11223344);
    do_xfer("w_byte", 1'b1, 32'h13, 3'd0, 32'hAAAAAAAA);
    do_xfer("r_byte", 1'b0, 32'h10, 3'd2, 32'h0);

    do_xfer("w_zero", 1'b1, 32'h0, 3'd2, 32'h0BADF00D);
    do_xfer("w_oor", 1'b1, 32'h4000, 3'd2, 32'hFFFFFFFF);
    do_xfer("r_zero", 1'b0, 32'h0, 3'd2, 32'h0);
    do_xfer("w_mis", 1'b1, 32'h2, 3'd2, 32'hCAFEF00D);
    do_xfer("r_mis", 1'b0, 32'h0, 3'd2, 32'h0);

    for (int i = 0; i < 16; i++)
      do_xfer("init", 1'b1, 32'(i * 4), 3'd2, $urandom);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'h1000 + ($urandom_range(0, 255) << 2);
      else
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      s = 3'($urandom_range(0, 3));
      do_xfer("rand", 1'($urandom_range(0, 1)), a, s, $urandom);
    end

    do_xfer("w_pre", 1'b1, 32'h20, 3'd2, 32'h600DCAFE);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBAD0BAD0;
    check("rstw/in_wait", 32'(hready), 32'd0);
    hreset = 1'b1;
    @(negedge hclk);
    check("rstw/ready", 32'(hready), 32'd1);
    check("rstw/resp", 32'(hresp_m), 32'd0);
    hreset = 1'b0;
    do_xfer("rstw/read", 1'b0, 32'h20, 3'd2, 32'h0);

    ws0_sel = 1'b1;
    for (int i = 0; i < 8; i++)
      do_xfer("init0", 1'b1, 32'(i * 4), 3'd2, $urandom);
    for (int k = 0; k <= 8; k++) begin
      @(negedge hclk);
      if (k > 0) begin
        check("b2b/ready", 32'(hready), 32'd1);
        check("b2b/resp", 32'(hresp_m), 32'd0);
        check("b2b/rdata", hrdata_m, ref_mem[k-1]);
      end
      if (k < 8) begin
        hsel = 1'b1; htrans = 2'b10; haddr = 32'(k * 4);
        hwrite = 1'b0; hsize = 3'd2;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
    end

    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h1C; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    check("raw/wr_ready", 32'(hready), 32'd1);
    hwdata = 32'h13579BDF;
    model_write(32'h1C, 3'd2, 32'h13579BDF);
    hwrite = 1'b0;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00;
    check("raw/rd_ready", 32'(hready), 32'd1);
    check("raw/rdata", hrdata_m, ref_mem[7]);
    @(negedge hclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
